// File: rtl/nbcac_pkg.sv
// Shared NBCAC constants and the weighted partial-sum helper used by the
// decoder datapath and by encoder-side bench models.
package nbcac_pkg;

    localparam int NBCAC_W = 10;
    localparam int DATA_W  = 7;
    localparam int SUM_W   = 8;
    localparam int PSB_W   = 5;

    // Weight of codeword bit d[i] lives in S[i]; cw[i-1] carries d[i].
    localparam logic [SUM_W-1:0] S [1:NBCAC_W] = '{
        8'd1, 8'd68, 8'd42, 8'd26, 8'd16, 8'd10, 8'd6, 8'd4, 8'd2, 8'd2
    };

    function automatic logic [SUM_W-1:0] nbcac_psum(
        input logic [NBCAC_W-1:0] d,
        input int                 lo,
        input int                 hi
    );
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 1; i <= NBCAC_W; i++) begin
            if (i >= lo && i <= hi && d[i-1]) begin
                acc = acc + S[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/nbcac_7di_decoder_pipe_if.sv
// Codeword-in / data-out bus of the NBCAC decoder, including the error
// counter sideband.
interface nbcac_7di_decoder_pipe_if
    import nbcac_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) ();

    logic                 cw_valid;
    logic                 cw_ready;
    logic [NBCAC_W-1:0]   cw;
    logic                 dat_valid;
    logic                 dat_ready;
    logic [DATA_W-1:0]    dat;
    logic                 dat_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output cw_valid, cw, dat_ready, err_clr,
        input  cw_ready, dat_valid, dat, dat_err, err_cnt
    );

    modport slave (
        input  cw_valid, cw, dat_ready, err_clr,
        output cw_ready, dat_valid, dat, dat_err, err_cnt
    );

endinterface

// File: rtl/nbcac_pipe_stage.sv
// Generic valid/ready register slice: loads whenever it is empty or the
// downstream side is taking the current word.
module nbcac_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Payload only moves with a valid word so a stalled or idle slice keeps
    // its last value stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/nbcac_7di_decoder_pipe.sv
// NBCAC 10-bit codeword to 7-bit data decoder: two-stage valid/ready pipe
// with out-of-range flagging and a saturating error counter.
module nbcac_7di_decoder_pipe
    import nbcac_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    nbcac_7di_decoder_pipe_if.slave bus
);

    localparam int S1_W = SUM_W + PSB_W;

    logic [SUM_W-1:0]     w_psa;
    logic [PSB_W-1:0]     w_psb;
    logic [S1_W-1:0]      w_s1_data;
    logic                 w_s1_valid;
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_sum_q;
    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_err_inc;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // d6..d10 weigh at most 24, so the low partial sum fits in 5 bits.
    assign w_psa = nbcac_psum(bus.cw, 1, 5);
    assign w_psb = PSB_W'(nbcac_psum(bus.cw, 6, 10));

    nbcac_pipe_stage #(.W(S1_W)) u_stage1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (bus.cw_valid),
        .i_data  ({w_psa, w_psb}),
        .o_ready (w_adv1),
        .i_ready (w_adv2),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_data)
    );

    assign w_sum = w_s1_data[S1_W-1:PSB_W] + {{(SUM_W-PSB_W){1'b0}}, w_s1_data[PSB_W-1:0]};

    nbcac_pipe_stage #(.W(SUM_W)) u_stage2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_s1_valid),
        .i_data  (w_sum),
        .o_ready (w_adv2),
        .i_ready (bus.dat_ready),
        .o_valid (bus.dat_valid),
        .o_data  (w_sum_q)
    );

    assign bus.cw_ready = w_adv1;
    assign bus.dat      = w_sum_q[DATA_W-1:0];
    assign bus.dat_err  = (w_sum_q > 8'd127);

    assign w_err_inc = bus.dat_valid && bus.dat_ready && bus.dat_err;

    // A clear that coincides with a counted error leaves that error counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= w_err_inc ? ERR_CNT_W'(1) : '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_nbcac_7di_decoder_pipe.sv
// Directed bench for the NBCAC decoder pipe: latency, back-to-back flow,
// stalls, exhaustive in-range decode, error counter saturation and reset.
module tb_nbcac_7di_decoder_pipe;

    localparam int ECW = 2;

    logic clk;
    logic rst_n;

    nbcac_7di_decoder_pipe_if #(.ERR_CNT_W(ECW)) bus ();

    nbcac_7di_decoder_pipe #(.ERR_CNT_W(ECW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [7:0] exp_q[$];
    bit thr_on = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Greedy over weights 68..2 then 1 always lands exactly for 0..127.
    function automatic logic [9:0] enc(input int v);
        int wt [10] = '{1, 68, 42, 26, 16, 10, 6, 4, 2, 2};
        logic [9:0] c;
        int r;
        c = '0;
        r = v;
        for (int i = 1; i < 10; i++) begin
            if (r >= wt[i]) begin
                c[i] = 1'b1;
                r = r - wt[i];
            end
        end
        if (r >= 1) c[0] = 1'b1;
        return c;
    endfunction

    task automatic send(input logic [9:0] c, input logic [6:0] d, input logic e);
        bit ok;
        ok = 0;
        bus.cw = c;
        bus.cw_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.cw_ready) begin
                exp_q.push_back({e, d});
                n_acc++;
                ok = 1;
            end
            @(posedge clk); #1;
        end
        bus.cw_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Output scoreboard: every delivered word must match the oldest accepted one.
    always @(negedge clk) begin
        if (rst_n && bus.dat_valid && bus.dat_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                logic [7:0] x;
                x = exp_q.pop_front();
                chk("dat", {25'd0, bus.dat}, {25'd0, x[6:0]});
                chk("dat_err", {31'd0, bus.dat_err}, {31'd0, x[7]});
            end
        end
    end

    always @(posedge clk) begin
        if (thr_on) begin
            #1;
            if (thr_on) bus.dat_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int base;
        bit seen;
        rst_n = 1'b0;
        bus.cw_valid = 1'b0;
        bus.cw = '0;
        bus.dat_ready = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dat_valid", {31'd0, bus.dat_valid}, 32'd0);
        chk("rst_dat", {25'd0, bus.dat}, 32'd0);
        chk("rst_dat_err", {31'd0, bus.dat_err}, 32'd0);
        chk("rst_cw_ready", {31'd0, bus.cw_ready}, 32'd1);
        chk("rst_err_cnt", {30'd0, bus.err_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.dat_ready = 1'b1;

        // Two-cycle latency
        send(10'h000, 7'd0, 1'b0);
        @(negedge clk);
        chk("lat_c1_valid", {31'd0, bus.dat_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", {31'd0, bus.dat_valid}, 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back, no bubbles
        @(posedge clk); #1;
        send(10'h001, 7'd1, 1'b0);
        send(10'h067, 7'd127, 1'b0);
        @(negedge clk);
        chk("b2b_valid0", {31'd0, bus.dat_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_valid1", {31'd0, bus.dat_valid}, 32'd1);
        repeat (3) @(negedge clk);

        // Out-of-range word and counter
        chk("err_cnt_pre", {30'd0, bus.err_cnt}, 32'd0);
        @(posedge clk); #1;
        send(10'h3FF, 7'd49, 1'b1);
        repeat (4) @(negedge clk);
        chk("err_cnt_one", {30'd0, bus.err_cnt}, 32'd1);

        // Stall: only two words fit while the sink is blocked
        @(posedge clk); #1;
        bus.dat_ready = 1'b0;
        base = n_out;
        n_acc = 0;
        fork
            begin
                send(10'h004, 7'd42, 1'b0);
                send(10'h010, 7'd16, 1'b0);
                send(10'h200, 7'd2, 1'b0);
                send(10'h0A5, 7'd57, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("stall_cw_ready", {31'd0, bus.cw_ready}, 32'd0);
                chk("stall_dat_valid", {31'd0, bus.dat_valid}, 32'd1);
                chk("stall_accepted", n_acc, 32'd2);
                @(posedge clk); #1;
                bus.dat_ready = 1'b1;
                @(negedge clk);
                chk("release_cw_ready", {31'd0, bus.cw_ready}, 32'd1);
            end
        join
        repeat (5) @(negedge clk);
        chk("stall_out_count", n_out - base, 32'd4);
        chk("stall_q_empty", exp_q.size(), 32'd0);

        // Exhaustive in-range sweep with random throttling on both sides
        @(posedge clk); #1;
        base = n_out;
        thr_on = 1;
        for (int v = 0; v < 128; v++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(enc(v), 7'(v), 1'b0);
        end
        thr_on = 0;
        @(posedge clk); #1;
        bus.dat_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("sweep_out_count", n_out - base, 32'd128);
        chk("sweep_q_empty", exp_q.size(), 32'd0);
        chk("sweep_err_cnt", {30'd0, bus.err_cnt}, 32'd1);

        // Clear, then saturate a 2-bit counter
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err_cnt", {30'd0, bus.err_cnt}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) send(10'h3FF, 7'd49, 1'b1);
        repeat (4) @(negedge clk);
        chk("sat_err_cnt", {30'd0, bus.err_cnt}, 32'd3);

        // Clear colliding with a counted error
        @(posedge clk); #1;
        bus.dat_ready = 1'b0;
        send(10'h3FF, 7'd49, 1'b1);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.dat_valid) seen = 1;
        end
        chk("clr_inc_wait", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        bus.dat_ready = 1'b1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("clr_inc_err_cnt", {30'd0, bus.err_cnt}, 32'd1);

        // Asynchronous reset with words in flight
        @(posedge clk); #1;
        bus.dat_ready = 1'b0;
        send(10'h001, 7'd1, 1'b0);
        send(10'h002, 7'd68, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dat_valid", {31'd0, bus.dat_valid}, 32'd0);
        chk("mid_rst_err_cnt", {30'd0, bus.err_cnt}, 32'd0);
        chk("mid_rst_cw_ready", {31'd0, bus.cw_ready}, 32'd1);
        chk("mid_rst_dat", {25'd0, bus.dat}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.dat_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, bus.dat_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
